// File: rtl/cu_edge_data_read_engine_if.sv
// Bus bundle for the CU edge data read engine: edge job input, read command
// output, half-cacheline response input and in-order data output.
interface cu_edge_data_read_engine_if #(
  parameter int DATA_BITS     = 32,
  parameter int CL_BITS       = 1024,
  parameter int NUM_TAGS      = 8,
  parameter int EDGE_IDX_BITS = 32
);
  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int OFF_W = $clog2(CL_BITS / DATA_BITS);

  logic                     edge_valid;
  logic [EDGE_IDX_BITS-1:0] edge_dest;
  logic                     edge_ready;

  logic                     cmd_valid;
  logic [63:0]              cmd_address;
  logic [TAG_W-1:0]         cmd_tag;
  logic [OFF_W-1:0]         cmd_offset;
  logic [7:0]               cmd_cu_id;
  logic                     cmd_ready;

  logic                     rsp_valid;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     rsp_half;
  logic [CL_BITS/2-1:0]     rsp_data;

  logic                     out_valid;
  logic [DATA_BITS-1:0]     out_data;
  logic                     out_ready;

  // Engine side
  modport slave (
    input  edge_valid, edge_dest, output edge_ready,
    output cmd_valid, cmd_address, cmd_tag, cmd_offset, cmd_cu_id, input cmd_ready,
    input  rsp_valid, rsp_tag, rsp_half, rsp_data,
    output out_valid, out_data, input out_ready
  );

  // Environment side
  modport master (
    output edge_valid, edge_dest, input edge_ready,
    input  cmd_valid, cmd_address, cmd_tag, cmd_offset, cmd_cu_id, output cmd_ready,
    output rsp_valid, rsp_tag, rsp_half, rsp_data,
    input  out_valid, out_data, output out_ready
  );
endinterface

// File: rtl/cu_edge_data_read_engine.sv
// CU edge data read engine: one read per edge for the destination vertex
// word, tag table reassembling two half-cacheline beats per tag in any
// order, and in-order delivery of the extracted word.
// Optional build macro: CU_EDGE_DATA_SWAP_EN byte-reverses out_data in the
// output register (same latency either way).
module cu_edge_data_read_engine #(
  parameter int CU_ID         = 1,
  parameter int DATA_BITS     = 32,
  parameter int CL_BITS       = 1024,
  parameter int NUM_TAGS      = 8,
  parameter int EDGE_IDX_BITS = 32,
  parameter int CNT_BITS      = 32
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  logic [63:0]                base_addr,
  input  logic                       count_clear,
  output logic [$clog2(NUM_TAGS):0]  outstanding,
  output logic [CNT_BITS-1:0]        pushed_count,
  output logic                       proto_error,
  cu_edge_data_read_engine_if.slave  bus
);
  localparam int TAG_W  = $clog2(NUM_TAGS);
  localparam int OFF_W  = $clog2(CL_BITS / DATA_BITS);
  localparam int SHIFT  = $clog2(DATA_BITS / 8);
  localparam logic [TAG_W:0]    FULL_CNT = (TAG_W+1)'(NUM_TAGS);
  localparam logic [TAG_W:0]    OUT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0]  TAG_ONE  = TAG_W'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_PARTIAL = 2'd2,
    S_DONE    = 2'd3
  } slot_state_e;

`ifdef CU_EDGE_DATA_SWAP_EN
  // Reverse the byte order of one data element.
  function automatic logic [DATA_BITS-1:0] byte_swap(input logic [DATA_BITS-1:0] w);
    logic [DATA_BITS-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_BITS / 8; b++) begin
      r[b*8 +: 8] = w[(DATA_BITS/8-1-b)*8 +: 8];
    end
    return r;
  endfunction
`endif

  logic                   enabled_q;
  logic [TAG_W-1:0]       alloc_ptr_q;
  logic [TAG_W-1:0]       retire_ptr_q;
  logic [TAG_W:0]         outstanding_q;
  logic [TAG_W:0]         outstanding_d;
  logic                   cmd_valid_q;
  logic [63:0]            cmd_addr_q;
  logic [TAG_W-1:0]       cmd_tag_q;
  logic [OFF_W-1:0]       cmd_off_q;
  slot_state_e            state_q [NUM_TAGS];
  slot_state_e            state_d [NUM_TAGS];
  logic [NUM_TAGS-1:0]    hlo_q;
  logic [NUM_TAGS-1:0]    hlo_d;
  logic [NUM_TAGS-1:0]    hhi_q;
  logic [NUM_TAGS-1:0]    hhi_d;
  logic [OFF_W-1:0]       off_q  [NUM_TAGS];
  logic [DATA_BITS-1:0]   word_q [NUM_TAGS];
  logic                   out_valid_q;
  logic [DATA_BITS-1:0]   out_data_q;
  logic [CNT_BITS-1:0]    pushed_q;
  logic                   proto_q;

  logic                   edge_ready_s;
  logic                   accept_s;
  logic                   retire_s;
  logic                   rsp_ok_s;
  logic                   rsp_err_s;
  logic                   cap_s;
  logic                   load_s;
  logic [TAG_W-1:0]       next_head_s;
  logic [OFF_W-1:0]       rsp_off_s;
  logic [DATA_BITS-1:0]   rsp_word_s;
  logic [DATA_BITS-1:0]   load_word_s;

  // Handshakes, response classification and selection of the addressed word
  always_comb begin
    edge_ready_s = enabled_q && (outstanding_q < FULL_CNT) && (!cmd_valid_q || bus.cmd_ready);
    accept_s     = bus.edge_valid && edge_ready_s;
    retire_s     = out_valid_q && bus.out_ready;
    rsp_off_s    = off_q[bus.rsp_tag];
    if (bus.rsp_valid && ((state_q[bus.rsp_tag] == S_PENDING) || (state_q[bus.rsp_tag] == S_PARTIAL))) begin
      rsp_ok_s = bus.rsp_half ? !hhi_q[bus.rsp_tag] : !hlo_q[bus.rsp_tag];
    end else begin
      rsp_ok_s = 1'b0;
    end
    rsp_err_s  = bus.rsp_valid && !rsp_ok_s;
    cap_s      = rsp_ok_s && (bus.rsp_half == rsp_off_s[OFF_W-1]);
    rsp_word_s = bus.rsp_data[int'(rsp_off_s[OFF_W-2:0])*DATA_BITS +: DATA_BITS];
    case ({accept_s, retire_s})
      2'b10:   outstanding_d = outstanding_q + OUT_ONE;
      2'b01:   outstanding_d = outstanding_q - OUT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Slot FSM next state: alloc, beat arrival and retire never hit the same slot
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      state_d[i] = state_q[i];
      hlo_d[i]   = hlo_q[i];
      hhi_d[i]   = hhi_q[i];
      if (accept_s && (alloc_ptr_q == TAG_W'(i))) begin
        state_d[i] = S_PENDING;
        hlo_d[i]   = 1'b0;
        hhi_d[i]   = 1'b0;
      end else if (retire_s && (retire_ptr_q == TAG_W'(i))) begin
        state_d[i] = S_IDLE;
      end else if (rsp_ok_s && (bus.rsp_tag == TAG_W'(i))) begin
        hlo_d[i] = hlo_q[i] | !bus.rsp_half;
        hhi_d[i] = hhi_q[i] | bus.rsp_half;
        case (state_q[i])
          S_PENDING: state_d[i] = S_PARTIAL;
          S_PARTIAL: state_d[i] = S_DONE;
          default:   state_d[i] = state_q[i];
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Slot FSM outputs: load the next in-order word when the head slot is complete
  always_comb begin
    next_head_s = retire_s ? (retire_ptr_q + TAG_ONE) : retire_ptr_q;
    if (enabled_q && (!out_valid_q || retire_s) && (state_q[next_head_s] == S_DONE)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
`ifdef CU_EDGE_DATA_SWAP_EN
    load_word_s = byte_swap(word_q[next_head_s]);
`else
    load_word_s = word_q[next_head_s];
`endif
  end

  // Slot FSM state register with half-arrival flags
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_q[i] <= S_IDLE;
      end
      hlo_q <= '0;
      hhi_q <= '0;
    end else begin
      state_q <= state_d;
      hlo_q   <= hlo_d;
      hhi_q   <= hhi_d;
    end
  end

  // Slot payload: word offset at allocation, addressed word on its beat
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        off_q[i]  <= '0;
        word_q[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        off_q[alloc_ptr_q] <= bus.edge_dest[OFF_W-1:0];
      end
      if (cap_s) begin
        word_q[bus.rsp_tag] <= rsp_word_s;
      end
    end
  end

  // Enable register, ring pointers and in-flight count
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q     <= 1'b0;
      alloc_ptr_q   <= '0;
      retire_ptr_q  <= '0;
      outstanding_q <= '0;
    end else begin
      enabled_q     <= enabled_in;
      outstanding_q <= outstanding_d;
      if (accept_s) begin
        alloc_ptr_q <= alloc_ptr_q + TAG_ONE;
      end
      if (retire_s) begin
        retire_ptr_q <= retire_ptr_q + TAG_ONE;
      end
    end
  end

  // Read command register, held stable while the downstream stalls
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_tag_q   <= '0;
      cmd_off_q   <= '0;
    end else if (accept_s) begin
      cmd_valid_q <= 1'b1;
      cmd_addr_q  <= base_addr + (64'(bus.edge_dest) << SHIFT);
      cmd_tag_q   <= alloc_ptr_q;
      cmd_off_q   <= bus.edge_dest[OFF_W-1:0];
    end else if (bus.cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // In-order output register, held until the consumer accepts
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load_s) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_word_s;
    end else if (retire_s) begin
      out_valid_q <= 1'b0;
    end
  end

  // Delivered-word counter and sticky protocol error
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pushed_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      if (count_clear) begin
        pushed_q <= '0;
      end else if (retire_s) begin
        pushed_q <= pushed_q + CNT_ONE;
      end
      if (rsp_err_s) begin
        proto_q <= 1'b1;
      end
    end
  end

  assign bus.edge_ready  = edge_ready_s;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_address = cmd_addr_q;
  assign bus.cmd_tag     = cmd_tag_q;
  assign bus.cmd_offset  = cmd_off_q;
  assign bus.cmd_cu_id   = 8'(CU_ID);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign outstanding     = outstanding_q;
  assign pushed_count    = pushed_q;
  assign proto_error     = proto_q;

endmodule

// File: tb/tb_cu_edge_data_read_engine.sv
// Directed self-checking bench for cu_edge_data_read_engine (default params).
module tb_cu_edge_data_read_engine;
  logic        clock = 1'b0;
  logic        rstn;
  logic        enabled_in;
  logic [63:0] base_addr;
  logic        count_clear;
  logic [3:0]  outstanding;
  logic [31:0] pushed_count;
  logic        proto_error;
  int checks = 0;
  int errors = 0;

  cu_edge_data_read_engine_if #(.DATA_BITS(32), .CL_BITS(1024), .NUM_TAGS(8), .EDGE_IDX_BITS(32)) bus ();

  cu_edge_data_read_engine #(
    .CU_ID(1), .DATA_BITS(32), .CL_BITS(1024), .NUM_TAGS(8), .EDGE_IDX_BITS(32), .CNT_BITS(32)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .base_addr(base_addr),
    .count_clear(count_clear), .outstanding(outstanding), .pushed_count(pushed_count),
    .proto_error(proto_error), .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef CU_EDGE_DATA_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.edge_valid = 1'b0; bus.edge_dest = 32'd0; bus.cmd_ready = 1'b1;
    bus.rsp_valid = 1'b0; bus.rsp_tag = 3'd0; bus.rsp_half = 1'b0; bus.rsp_data = '0;
    bus.out_ready = 1'b0; count_clear = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic accept_edge(input logic [31:0] dest);
    int n;
    n = 0;
    bus.edge_valid = 1'b1;
    bus.edge_dest  = dest;
    #1;
    while (!bus.edge_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (bus.edge_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout dest=%0d edge_ready=%b required 1", dest, bus.edge_ready);
    end
    @(posedge clock); #1;
    bus.edge_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [2:0] tag, input logic half, input int idx, input logic [31:0] val);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) begin
      d[k*32 +: 32] = 32'h5A5A_0000 | 32'(k) | (half ? 32'h0000_0100 : 32'h0000_0000);
    end
    d[idx*32 +: 32] = val;
    bus.rsp_valid = 1'b1; bus.rsp_tag = tag; bus.rsp_half = half; bus.rsp_data = d;
    @(posedge clock); #1;
    bus.rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled_in = 1'b0; base_addr = 64'd0; count_clear = 1'b0;
    bus.edge_valid = 1'b1; bus.edge_dest = 32'd0; bus.cmd_ready = 1'b1;
    bus.rsp_valid = 1'b0; bus.rsp_tag = 3'd0; bus.rsp_half = 1'b0; bus.rsp_data = '0;
    bus.out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (bus.edge_ready !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.out_valid !== 1'b0 ||
        outstanding !== 4'd0 || pushed_count !== 32'd0 || proto_error !== 1'b0 ||
        bus.cmd_address !== 64'd0 || bus.out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs er=%b cv=%b ov=%b out=%0d pc=%0d pe=%b required all 0",
               bus.edge_ready, bus.cmd_valid, bus.out_valid, outstanding, pushed_count, proto_error);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.edge_ready !== 1'b0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL disabled_no_accept edge_ready=%b cmd_valid=%b required 0 0", bus.edge_ready, bus.cmd_valid);
    end
    enabled_in = 1'b1;
    bus.edge_valid = 1'b0;
    tick();
    checks++;
    if (bus.edge_ready !== 1'b1) begin
      errors++;
      $display("FAIL enable_ready edge_ready=%b required 1", bus.edge_ready);
    end
  endtask

  task automatic test_single();
    base_addr = 64'h1000;
    do_reset();
    accept_edge(32'd5);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_address !== 64'h1014 || bus.cmd_offset !== 5'd5 ||
        bus.cmd_tag !== 3'd0 || bus.cmd_cu_id !== 8'd1 || outstanding !== 4'd1) begin
      errors++;
      $display("FAIL single_cmd v=%b addr=%h off=%0d tag=%0d cu=%0d out=%0d required 1 1014 5 0 1 1",
               bus.cmd_valid, bus.cmd_address, bus.cmd_offset, bus.cmd_tag, bus.cmd_cu_id, outstanding);
    end
    send_beat(3'd0, 1'b0, 5, 32'hDEAD_BEEF);
    send_beat(3'd0, 1'b1, 5, 32'h1111_1111);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency1 out_valid=%b cmd_valid=%b required 0 0", bus.out_valid, bus.cmd_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word(32'hDEAD_BEEF)) begin
      errors++;
      $display("FAIL single_data valid=%b data=%h required 1 %h", bus.out_valid, bus.out_data, exp_word(32'hDEAD_BEEF));
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word(32'hDEAD_BEEF) || pushed_count !== 32'd0) begin
      errors++;
      $display("FAIL single_hold valid=%b data=%h pc=%0d required 1 %h 0", bus.out_valid, bus.out_data, pushed_count, exp_word(32'hDEAD_BEEF));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || pushed_count !== 32'd1 || outstanding !== 4'd0) begin
      errors++;
      $display("FAIL single_retire valid=%b pc=%0d out=%0d required 0 1 0", bus.out_valid, pushed_count, outstanding);
    end
  endtask

  task automatic test_order();
    int k;
    int cyc;
    int first;
    int last;
    base_addr = 64'h0;
    do_reset();
    for (int i = 0; i < 8; i++) accept_edge(32'(i));
    checks++;
    if (outstanding !== 4'd8 || bus.edge_ready !== 1'b0) begin
      errors++;
      $display("FAIL order_full outstanding=%0d edge_ready=%b required 8 0", outstanding, bus.edge_ready);
    end
    for (int j = 7; j >= 0; j--) begin
      send_beat(3'(j), 1'b1, 0, 32'hFFFF_FFFF);
      send_beat(3'(j), 1'b0, j, 32'hA000_0000 + 32'(j));
    end
    bus.out_ready = 1'b1;
    k = 0; cyc = 0; first = 0; last = 0;
    while (k < 8 && cyc < 40) begin
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_data !== exp_word(32'hA000_0000 + 32'(k))) begin
          errors++;
          $display("FAIL order_data idx=%0d data=%h required %h", k, bus.out_data, exp_word(32'hA000_0000 + 32'(k)));
        end
        if (k == 0) first = cyc;
        last = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (k != 8 || (last - first) != 7) begin
      errors++;
      $display("FAIL order_count outputs=%0d span=%0d required 8 7", k, last - first);
    end
    checks++;
    if (outstanding !== 4'd0 || pushed_count !== 32'd8 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_end outstanding=%0d pc=%0d valid=%b required 0 8 0", outstanding, pushed_count, bus.out_valid);
    end
  endtask

  task automatic test_full();
    int bad;
    base_addr = 64'h2000;
    do_reset();
    for (int i = 0; i < 8; i++) accept_edge(32'd16 + 32'(i));
    checks++;
    if (outstanding !== 4'd8) begin
      errors++;
      $display("FAIL full_count outstanding=%0d required 8", outstanding);
    end
    bus.edge_valid = 1'b1; bus.edge_dest = 32'd40;
    #1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.edge_ready !== 1'b0) bad++;
      tick();
    end
    send_beat(3'd0, 1'b0, 0, 32'h0000_0000);
    send_beat(3'd0, 1'b1, 0, 32'hC0FF_EE16);
    if (bus.edge_ready !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_block edge_ready high in %0d cycles required 0", bad);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word(32'hC0FF_EE16)) begin
      errors++;
      $display("FAIL full_head valid=%b data=%h required 1 %h", bus.out_valid, bus.out_data, exp_word(32'hC0FF_EE16));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (outstanding !== 4'd7 || bus.edge_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release outstanding=%0d edge_ready=%b required 7 1", outstanding, bus.edge_ready);
    end
    tick();
    bus.edge_valid = 1'b0;
    checks++;
    if (outstanding !== 4'd8 || bus.cmd_valid !== 1'b1 || bus.cmd_tag !== 3'd0 ||
        bus.cmd_offset !== 5'd8 || bus.cmd_address !== 64'h20A0) begin
      errors++;
      $display("FAIL full_ninth out=%0d cv=%b tag=%0d off=%0d addr=%h required 8 1 0 8 20a0",
               outstanding, bus.cmd_valid, bus.cmd_tag, bus.cmd_offset, bus.cmd_address);
    end
  endtask

  task automatic test_cmd_stall();
    int bad;
    base_addr = 64'hFFFF_FFFF_FFFF_FFF0;
    do_reset();
    bus.cmd_ready = 1'b0;
    accept_edge(32'd3);
    bus.edge_valid = 1'b1; bus.edge_dest = 32'd9;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid !== 1'b1 || bus.cmd_address !== 64'hFFFF_FFFF_FFFF_FFFC ||
          bus.cmd_tag !== 3'd0 || bus.cmd_offset !== 5'd3 || bus.edge_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable %0d unstable cycles required 0", bad);
    end
    bus.cmd_ready = 1'b1;
    #1;
    checks++;
    if (bus.edge_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release edge_ready=%b required 1", bus.edge_ready);
    end
    tick();
    bus.edge_valid = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_address !== 64'h14 || bus.cmd_tag !== 3'd1 ||
        bus.cmd_offset !== 5'd9 || outstanding !== 4'd2) begin
      errors++;
      $display("FAIL stall_next cv=%b addr=%h tag=%0d off=%0d out=%0d required 1 14 1 9 2",
               bus.cmd_valid, bus.cmd_address, bus.cmd_tag, bus.cmd_offset, outstanding);
    end
    tick();
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain cmd_valid=%b required 0", bus.cmd_valid);
    end
  endtask

  task automatic test_proto();
    base_addr = 64'h0;
    do_reset();
    accept_edge(32'd2);
    send_beat(3'd0, 1'b0, 2, 32'h1234_5678);
    checks++;
    if (proto_error !== 1'b0) begin
      errors++;
      $display("FAIL proto_clean proto_error=%b required 0", proto_error);
    end
    send_beat(3'd0, 1'b0, 2, 32'hBAD0_BAD0);
    checks++;
    if (proto_error !== 1'b1 || outstanding !== 4'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_dup pe=%b out=%0d valid=%b required 1 1 0", proto_error, outstanding, bus.out_valid);
    end
    send_beat(3'd0, 1'b1, 0, 32'h0000_0000);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_word(32'h1234_5678)) begin
      errors++;
      $display("FAIL proto_data valid=%b data=%h required 1 %h", bus.out_valid, bus.out_data, exp_word(32'h1234_5678));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    count_clear = 1'b1;
    checks++;
    if (pushed_count !== 32'd1) begin
      errors++;
      $display("FAIL proto_count pc=%0d required 1", pushed_count);
    end
    tick();
    count_clear = 1'b0;
    checks++;
    if (pushed_count !== 32'd0) begin
      errors++;
      $display("FAIL count_clear pc=%0d required 0", pushed_count);
    end
    do_reset();
    checks++;
    if (proto_error !== 1'b0) begin
      errors++;
      $display("FAIL proto_reset proto_error=%b required 0", proto_error);
    end
    send_beat(3'd3, 1'b0, 0, 32'h0000_0000);
    checks++;
    if (proto_error !== 1'b1 || outstanding !== 4'd0 || bus.out_valid !== 1'b0 || pushed_count !== 32'd0) begin
      errors++;
      $display("FAIL proto_idle pe=%b out=%0d valid=%b pc=%0d required 1 0 0 0",
               proto_error, outstanding, bus.out_valid, pushed_count);
    end
  endtask

  task automatic test_reset_mid();
    base_addr = 64'h4000;
    do_reset();
    accept_edge(32'd1);
    accept_edge(32'd7);
    send_beat(3'd0, 1'b0, 1, 32'h0BAD_F00D);
    send_beat(3'd0, 1'b1, 1, 32'h0000_0000);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || outstanding !== 4'd2) begin
      errors++;
      $display("FAIL mid_head valid=%b out=%0d required 1 2", bus.out_valid, outstanding);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.cmd_valid !== 1'b0 ||
        outstanding !== 4'd0 || pushed_count !== 32'd0 || bus.edge_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ov=%b od=%h cv=%b out=%0d pc=%0d er=%b required all 0",
               bus.out_valid, bus.out_data, bus.cmd_valid, outstanding, pushed_count, bus.edge_ready);
    end
    @(negedge clock);
    rstn = 1'b1;
    tick();
    accept_edge(32'd6);
    checks++;
    if (bus.cmd_tag !== 3'd0 || bus.cmd_address !== 64'h4018 || outstanding !== 4'd1) begin
      errors++;
      $display("FAIL mid_after tag=%0d addr=%h out=%0d required 0 4018 1", bus.cmd_tag, bus.cmd_address, outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_cmd_stall();
    test_proto();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
